// File: rtl/mario_vertical_motion_pkg.sv
// Shared definitions for Mario's vertical motion: FSM state type and the
// default screen/motion constants also used by the renderer and collision logic.
package mario_vertical_motion_pkg;

  localparam int unsigned DEF_Y_W         = 10;
  localparam int unsigned DEF_HOLD_W      = 7;
  localparam int unsigned DEF_GROUND_Y    = 400;
  localparam int unsigned DEF_Y_MIN       = 64;
  localparam int unsigned DEF_RISE_STEP   = 3;
  localparam int unsigned DEF_MAX_HOLD    = 120;
  localparam int unsigned DEF_APEX_FRAMES = 4;
  localparam int unsigned DEF_V_MAX       = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASCEND = 2'd1,
    ST_APEX   = 2'd2,
    ST_FALL   = 2'd3
  } motion_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mario_vertical_motion_if.sv
// Jump request handshake between the button-hold measurement logic (master)
// and the vertical motion block (slave).
interface mario_vertical_motion_if
  import mario_vertical_motion_pkg::*;
#(
  parameter int unsigned HOLD_W = DEF_HOLD_W
) ();

  logic              jump_req;
  logic [HOLD_W-1:0] jump_frames;
  logic              jump_ack;

  modport master (output jump_req, output jump_frames, input jump_ack);
  modport slave  (input jump_req, input jump_frames, output jump_ack);

endinterface

// File: rtl/mario_vertical_motion.sv
// Mario vertical trajectory: takes an accepted jump request and produces
// ascent, apex hang and gravity fall back to the ground row. Motion advances
// on frame_tick only; all outputs are registered.
module mario_vertical_motion
  import mario_vertical_motion_pkg::*;
#(
  parameter int unsigned Y_W         = DEF_Y_W,
  parameter int unsigned HOLD_W      = DEF_HOLD_W,
  parameter int unsigned GROUND_Y    = DEF_GROUND_Y,
  parameter int unsigned Y_MIN       = DEF_Y_MIN,
  parameter int unsigned RISE_STEP   = DEF_RISE_STEP,
  parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD,
  parameter int unsigned APEX_FRAMES = DEF_APEX_FRAMES,
  parameter int unsigned V_MAX       = DEF_V_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  mario_vertical_motion_if.slave  jmp,
  output logic [Y_W-1:0]          y_pos,
  output logic                    airborne,
  output logic                    land_pulse
);

  localparam int unsigned VEL_W = cnt_w(V_MAX);
  localparam int unsigned APX_W = cnt_w(APEX_FRAMES);

  typedef logic [Y_W-1:0]    y_t;
  typedef logic [Y_W:0]      ext_t;
  typedef logic [HOLD_W-1:0] hold_t;
  typedef logic [VEL_W-1:0]  vel_t;
  typedef logic [APX_W-1:0]  apx_t;

  motion_state_t state;
  hold_t         rise_cnt;
  apx_t          apex_cnt;
  vel_t          vel;

  ext_t  y_ext;
  vel_t  vel_next;
  ext_t  fall_sum;
  logic  at_ceiling;
  y_t    rise_y;
  hold_t hold_clamped;

  // Next-step arithmetic, one bit wider than y_pos so compares cannot wrap.
  always_comb begin
    y_ext        = {1'b0, y_pos};
    vel_next     = (vel >= vel_t'(V_MAX)) ? vel_t'(V_MAX) : vel + 1'b1;
    fall_sum     = y_ext + ext_t'(vel_next);
    at_ceiling   = (y_ext <= ext_t'(Y_MIN + RISE_STEP));
    rise_y       = y_pos - y_t'(RISE_STEP);
    hold_clamped = (jmp.jump_frames > hold_t'(MAX_HOLD)) ? hold_t'(MAX_HOLD)
                                                         : jmp.jump_frames;
  end

  // Trajectory FSM with registered outputs; jump requests are only seen in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      y_pos        <= y_t'(GROUND_Y);
      vel          <= '0;
      rise_cnt     <= '0;
      apex_cnt     <= '0;
      airborne     <= 1'b0;
      jmp.jump_ack <= 1'b0;
      land_pulse   <= 1'b0;
    end else begin
      jmp.jump_ack <= 1'b0;
      land_pulse   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (jmp.jump_req && (jmp.jump_frames != '0)) begin
            rise_cnt     <= hold_clamped;
            jmp.jump_ack <= 1'b1;
            airborne     <= 1'b1;
            state        <= ST_ASCEND;
          end
        end
        ST_ASCEND: begin
          if (frame_tick) begin
            if (at_ceiling) begin
              y_pos    <= y_t'(Y_MIN);
              rise_cnt <= '0;
              apex_cnt <= apx_t'(APEX_FRAMES);
              state    <= ST_APEX;
            end else begin
              y_pos    <= rise_y;
              rise_cnt <= rise_cnt - 1'b1;
              if (rise_cnt <= hold_t'(1)) begin
                apex_cnt <= apx_t'(APEX_FRAMES);
                state    <= ST_APEX;
              end
            end
          end
        end
        ST_APEX: begin
          if (frame_tick) begin
            if (apex_cnt <= apx_t'(1)) begin
              apex_cnt <= '0;
              vel      <= '0;
              state    <= ST_FALL;
            end else begin
              apex_cnt <= apex_cnt - 1'b1;
            end
          end
        end
        ST_FALL: begin
          if (frame_tick) begin
            if (fall_sum >= ext_t'(GROUND_Y)) begin
              y_pos      <= y_t'(GROUND_Y);
              vel        <= '0;
              land_pulse <= 1'b1;
              airborne   <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              y_pos <= fall_sum[Y_W-1:0];
              vel   <= vel_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mario_vertical_motion.sv
// Bench for mario_vertical_motion: a trajectory-list reference model, per-cycle
// comparison of all outputs, directed scenarios and randomized traffic.
module tb_mario_vertical_motion;

  localparam int GND  = 400;
  localparam int YMIN = 64;
  localparam int STEP = 3;
  localparam int MAXH = 120;
  localparam int APX  = 4;
  localparam int VMAX = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] y_pos;
  logic       airborne;
  logic       land_pulse;

  mario_vertical_motion_if #(.HOLD_W(7)) jmp ();

  mario_vertical_motion #(.Y_W(10), .HOLD_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .jmp        (jmp),
    .y_pos      (y_pos),
    .airborne   (airborne),
    .land_pulse (land_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: remaining trajectory as a list of rows, one per future frame tick.
  int q[$];
  bit m_air;
  int m_y;
  bit m_ack;
  bit m_land;
  int tick_in_jump;
  int div_cnt;
  int ft_div;

  int lit1[22] = '{397, 394, 391, 388, 385, 382, 379, 376, 373, 370,
                   370, 370, 370, 370,
                   371, 373, 376, 380, 385, 391, 397, 400};

  function automatic void build(int jf);
    int  rc;
    int  y;
    int  v;
    bit  done;
    rc = (jf > MAXH) ? MAXH : jf;
    y  = GND;
    v  = 0;
    q.delete();
    for (int i = 0; i < rc; i++) begin
      if (y - STEP <= YMIN) begin
        y = YMIN;
        q.push_back(y);
        break;
      end
      y = y - STEP;
      q.push_back(y);
    end
    for (int i = 0; i < APX; i++) q.push_back(y);
    done = 1'b0;
    while (!done) begin
      v = (v + 1 > VMAX) ? VMAX : v + 1;
      if (y + v >= GND) begin
        q.push_back(GND);
        done = 1'b1;
      end else begin
        y = y + v;
        q.push_back(y);
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_air  = 1'b0;
    m_y    = GND;
    m_ack  = 1'b0;
    m_land = 1'b0;
    q.delete();
  endtask

  task automatic model_edge();
    m_ack  = 1'b0;
    m_land = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_air) begin
      if (frame_tick) begin
        m_y = q.pop_front();
        tick_in_jump++;
        if (q.size() == 0) begin
          m_air  = 1'b0;
          m_land = 1'b1;
        end
      end
    end else if (jmp.jump_req && (jmp.jump_frames != 7'd0)) begin
      build(int'(jmp.jump_frames));
      m_air        = 1'b1;
      m_ack        = 1'b1;
      tick_in_jump = 0;
    end
  endtask

  task automatic compare_all();
    check("y_pos",      int'(y_pos),        m_y);
    check("airborne",   int'(airborne),     int'(m_air));
    check("jump_ack",   int'(jmp.jump_ack), int'(m_ack));
    check("land_pulse", int'(land_pulse),   int'(m_land));
  endtask

  // Drive inputs just after a falling edge, update model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit req, input int jf, input bit ft);
    jmp.jump_req    = req;
    jmp.jump_frames = 7'(jf);
    frame_tick      = ft;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic bit gen_ft();
    div_cnt++;
    if (div_cnt >= ft_div) begin
      div_cnt = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (m_air && n < budget) begin
      step(1'b0, 0, gen_ft());
      n++;
    end
    check(name, int'(airborne), 0);
  endtask

  initial begin
    int prev;
    int first64;
    int n;
    bit ft;
    bit req;
    int jf;
    int r;

    rst             = 1'b1;
    frame_tick      = 1'b0;
    jmp.jump_req    = 1'b0;
    jmp.jump_frames = '0;
    ft_div          = 3;
    div_cnt         = 0;
    tick_in_jump    = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_y",        int'(y_pos),        GND);
    check("reset_airborne", int'(airborne),     0);
    check("reset_ack",      int'(jmp.jump_ack), 0);
    check("reset_land",     int'(land_pulse),   0);
    rst = 1'b0;
    step(1'b0, 0, 1'b1);

    // 1: basic jump with literal trajectory
    step(1'b1, 10, 1'b0);
    check("t1_ack", int'(jmp.jump_ack), 1);
    n = 0;
    while (m_air && n < 200) begin
      prev = tick_in_jump;
      step(1'b0, 0, gen_ft());
      if (tick_in_jump != prev && tick_in_jump <= 22)
        check("t1_lit_y", int'(y_pos), lit1[tick_in_jump-1]);
      if (tick_in_jump == 22 && prev == 21)
        check("t1_land", int'(land_pulse), 1);
      n++;
    end
    check("t1_done", int'(airborne), 0);

    // 2: zero-length hold is refused
    step(1'b1, 0, 1'b0);
    check("t2_ack", int'(jmp.jump_ack), 0);
    step(1'b1, 0, 1'b1);
    check("t2_y", int'(y_pos), GND);
    check("t2_air", int'(airborne), 0);

    // 3: saturated hold hits the ceiling early
    step(1'b1, 127, 1'b0);
    first64 = -1;
    n = 0;
    while (m_air && n < 2000) begin
      step(1'b0, 0, gen_ft());
      if (first64 < 0 && y_pos == 10'd64) first64 = tick_in_jump;
      n++;
    end
    check("t3_ceiling_tick", first64, 112);
    check("t3_done", int'(airborne), 0);

    // 4: requests mid-ascent and on the landing cycle are ignored
    step(1'b1, 10, 1'b0);
    n = 0;
    while (m_air && n < 200) begin
      prev = tick_in_jump;
      ft   = gen_ft();
      req  = (tick_in_jump == 5) || (ft && q.size() == 1);
      step(req, 20, ft);
      if (tick_in_jump != prev && tick_in_jump <= 22)
        check("t4_lit_y", int'(y_pos), lit1[tick_in_jump-1]);
      n++;
    end
    check("t4_done", int'(airborne), 0);
    step(1'b0, 0, 1'b0);

    // 5: async reset mid-fall, then a normal short jump
    step(1'b1, 10, 1'b0);
    n = 0;
    while (!(m_y == 380 && tick_in_jump > 14) && n < 200) begin
      step(1'b0, 0, gen_ft());
      n++;
    end
    check("t5_reached_380", int'(y_pos), 380);
    rst = 1'b1;
    #2;
    check("t5_rst_y",   int'(y_pos),    GND);
    check("t5_rst_air", int'(airborne), 0);
    model_reset();
    step(1'b0, 0, 1'b0);
    rst = 1'b0;
    step(1'b1, 5, 1'b0);
    check("t5_ack", int'(jmp.jump_ack), 1);
    run_until_idle(300, "t5_done");

    // 6: request coincident with frame_tick
    step(1'b0, 0, 1'b0);
    step(1'b1, 7, 1'b1);
    check("t6_ack", int'(jmp.jump_ack), 1);
    check("t6_y0",  int'(y_pos), 400);
    step(1'b0, 0, 1'b1);
    check("t6_y1",  int'(y_pos), 397);
    run_until_idle(300, "t6_done");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ft  = ($urandom_range(0, 2) == 0);
      req = ($urandom_range(0, 7) == 0);
      r   = $urandom_range(0, 3);
      if (r == 0)      jf = 0;
      else if (r == 1) jf = $urandom_range(1, 10);
      else             jf = $urandom_range(0, 127);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step(req, jf, ft);
        rst = 1'b0;
      end else begin
        step(req, jf, ft);
      end
    end
    run_until_idle(2000, "rand_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
